// File: rtl/chip8_alu_dispatch.sv
// rtl/chip8_alu_dispatch.sv - CHIP-8 ALU request/done initiator and writeback sequencer
//
// Purpose:
//   Accepts one decoded arithmetic / logic / skip / I-add instruction with its
//   operand values, drives the ALU through reset -> issue -> done-wait and then
//   emits a single-cycle writeback bundle (VX, VF, I, skip).
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   cmd_valid / cmd_ready     instruction handshake (ready only when idle)
//   cmd_opcode, cmd_vx,
//   cmd_vy, cmd_i             raw opcode and operand values
//   alu_rst, alu_req          ALU reset and request bundle (stable during issue)
//   alu_result, alu_result_long,
//   alu_overflow, alu_done    ALU response (done is sticky until alu_rst)
//   wb_*                      one-cycle writeback bundle, all zero outside WB
//
// Parameters:
//   TIMEOUT_CYCLES            max issue cycles waiting for alu_done (min 4)
//
// Configuration macro:
//   CHIP8_VF_RESET_QUIRK_EN   when defined, 8XY1/8XY2/8XY3 also clear VF

package chip8_alu_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_SE   = 4'd8,
        ALU_SNE  = 4'd9,
        ALU_ADDL = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic [7:0]  operand_a;
        logic [7:0]  operand_b;
        logic [11:0] operand_b_long;
    } alu_input;

endpackage

module chip8_alu_dispatch
    import chip8_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_opcode,
    input  logic [7:0]  cmd_vx,
    input  logic [7:0]  cmd_vy,
    input  logic [15:0] cmd_i,
    output logic        alu_rst,
    output alu_input    alu_req,
    input  logic [7:0]  alu_result,
    input  logic [15:0] alu_result_long,
    input  logic        alu_overflow,
    input  logic        alu_done,
    output logic        wb_valid,
    output logic        wb_vx_en,
    output logic [3:0]  wb_vx_idx,
    output logic [7:0]  wb_vx_data,
    output logic        wb_vf_en,
    output logic [7:0]  wb_vf_data,
    output logic        wb_i_en,
    output logic [15:0] wb_i_data,
    output logic        wb_skip,
    output logic        wb_illegal,
    output logic        wb_timeout
);

`ifdef CHIP8_VF_RESET_QUIRK_EN
    localparam bit VF_QUIRK = 1'b1;
`else
    localparam bit VF_QUIRK = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    // Only I[11:0] feeds the ALU long operand.
    logic unused_i_hi;
    assign unused_i_hi = ^cmd_i[15:12];

    // ------------------------------------------------------------------
    // Opcode decode (combinational on the offered command)
    // ------------------------------------------------------------------
    alu_input   dec_req;
    logic       dec_vx_wr;
    logic       dec_vf_wr;
    logic       dec_vf_zero;
    logic       dec_i_wr;
    logic       dec_skip;
    logic       dec_bypass;
    logic       dec_illegal;
    logic [7:0] nn;
    logic [3:0] n_lo;

    assign nn   = cmd_opcode[7:0];
    assign n_lo = cmd_opcode[3:0];

    always_comb begin
        dec_req             = '0;
        dec_req.operand_a   = cmd_vx;
        dec_vx_wr           = 1'b0;
        dec_vf_wr           = 1'b0;
        dec_vf_zero         = 1'b0;
        dec_i_wr            = 1'b0;
        dec_skip            = 1'b0;
        dec_bypass          = 1'b0;
        dec_illegal         = 1'b0;
        case (cmd_opcode[15:12])
            4'h3: begin
                dec_req.op        = ALU_SE;
                dec_req.operand_b = nn;
                dec_skip          = 1'b1;
            end
            4'h4: begin
                dec_req.op        = ALU_SNE;
                dec_req.operand_b = nn;
                dec_skip          = 1'b1;
            end
            4'h5: begin
                if (n_lo == 4'h0) begin
                    dec_req.op        = ALU_SE;
                    dec_req.operand_b = cmd_vy;
                    dec_skip          = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            4'h9: begin
                if (n_lo == 4'h0) begin
                    dec_req.op        = ALU_SNE;
                    dec_req.operand_b = cmd_vy;
                    dec_skip          = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            4'h7: begin
                dec_req.op        = ALU_ADD;
                dec_req.operand_b = nn;
                dec_vx_wr         = 1'b1;
            end
            4'h8: begin
                dec_req.operand_b = cmd_vy;
                dec_vx_wr         = 1'b1;
                case (n_lo)
                    4'h0: dec_bypass = 1'b1;
                    4'h1, 4'h2, 4'h3: begin
                        dec_req.op  = (n_lo == 4'h1) ? ALU_OR :
                                      (n_lo == 4'h2) ? ALU_AND : ALU_XOR;
                        dec_vf_wr   = VF_QUIRK;
                        dec_vf_zero = 1'b1;
                    end
                    4'h4: begin
                        dec_req.op = ALU_ADD;
                        dec_vf_wr  = 1'b1;
                    end
                    4'h5: begin
                        dec_req.op = ALU_SUB;
                        dec_vf_wr  = 1'b1;
                    end
                    4'h7: begin
                        // Reverse subtract: VY - VX.
                        dec_req.op        = ALU_SUB;
                        dec_req.operand_a = cmd_vy;
                        dec_req.operand_b = cmd_vx;
                        dec_vf_wr         = 1'b1;
                    end
                    4'h6, 4'hE: begin
                        dec_req.op        = (n_lo == 4'h6) ? ALU_SHR : ALU_SHL;
                        dec_req.operand_b = 8'h01;
                        dec_vf_wr         = 1'b1;
                    end
                    default: begin
                        dec_vx_wr   = 1'b0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            4'hF: begin
                if (nn == 8'h1E) begin
                    dec_req.op             = ALU_ADDL;
                    dec_req.operand_b_long = cmd_i[11:0];
                    dec_i_wr               = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        // Bypass and illegal paths never touch the ALU.
        if (dec_bypass || dec_illegal) begin
            dec_req = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and latched command
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    alu_input         req_q, req_d;
    logic [3:0]       x_idx_q, x_idx_d;
    logic             vx_wr_q, vx_wr_d;
    logic             vf_wr_q, vf_wr_d;
    logic             vf_zero_q, vf_zero_d;
    logic             i_wr_q, i_wr_d;
    logic             skip_q, skip_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_vx_en_q, wb_vx_en_d;
    logic [3:0]       wb_vx_idx_q, wb_vx_idx_d;
    logic [7:0]       wb_vx_data_q, wb_vx_data_d;
    logic             wb_vf_en_q, wb_vf_en_d;
    logic [7:0]       wb_vf_data_q, wb_vf_data_d;
    logic             wb_i_en_q, wb_i_en_d;
    logic [15:0]      wb_i_data_q, wb_i_data_d;
    logic             wb_skip_q, wb_skip_d;
    logic             wb_illegal_q, wb_illegal_d;
    logic             wb_timeout_q, wb_timeout_d;

    logic             vf_flag;
    logic             vx_blocked;

    assign vf_flag    = vf_zero_q ? 1'b0 : alu_overflow;
    // VF as destination: the flag write takes priority over the result write.
    assign vx_blocked = vf_wr_q && (x_idx_q == 4'hF);

    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        req_d        = req_q;
        x_idx_d      = x_idx_q;
        vx_wr_d      = vx_wr_q;
        vf_wr_d      = vf_wr_q;
        vf_zero_d    = vf_zero_q;
        i_wr_d       = i_wr_q;
        skip_d       = skip_q;
        wb_valid_d   = 1'b0;
        wb_vx_en_d   = 1'b0;
        wb_vx_idx_d  = 4'h0;
        wb_vx_data_d = 8'h00;
        wb_vf_en_d   = 1'b0;
        wb_vf_data_d = 8'h00;
        wb_i_en_d    = 1'b0;
        wb_i_data_d  = 16'h0000;
        wb_skip_d    = 1'b0;
        wb_illegal_d = 1'b0;
        wb_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    req_d     = dec_req;
                    x_idx_d   = cmd_opcode[11:8];
                    vx_wr_d   = dec_vx_wr;
                    vf_wr_d   = dec_vf_wr;
                    vf_zero_d = dec_vf_zero;
                    i_wr_d    = dec_i_wr;
                    skip_d    = dec_skip;
                    tmo_cnt_d = '0;
                    if (dec_illegal) begin
                        state_d      = ST_WB;
                        wb_valid_d   = 1'b1;
                        wb_illegal_d = 1'b1;
                        wb_vx_idx_d  = cmd_opcode[11:8];
                    end else if (dec_bypass) begin
                        state_d      = ST_WB;
                        wb_valid_d   = 1'b1;
                        wb_vx_en_d   = 1'b1;
                        wb_vx_idx_d  = cmd_opcode[11:8];
                        wb_vx_data_d = cmd_vy;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (alu_done) begin
                    state_d      = ST_WB;
                    wb_valid_d   = 1'b1;
                    wb_vx_en_d   = vx_wr_q && !vx_blocked;
                    wb_vx_idx_d  = x_idx_q;
                    wb_vx_data_d = (vx_wr_q && !vx_blocked) ? alu_result : 8'h00;
                    wb_vf_en_d   = vf_wr_q;
                    wb_vf_data_d = vf_wr_q ? {7'b0, vf_flag} : 8'h00;
                    wb_i_en_d    = i_wr_q;
                    wb_i_data_d  = i_wr_q ? alu_result_long : 16'h0000;
                    wb_skip_d    = skip_q && alu_result[0];
                end else if (tmo_cnt_q == CNT_LAST) begin
                    state_d      = ST_WB;
                    wb_valid_d   = 1'b1;
                    wb_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            tmo_cnt_q    <= '0;
            req_q        <= '0;
            x_idx_q      <= 4'h0;
            vx_wr_q      <= 1'b0;
            vf_wr_q      <= 1'b0;
            vf_zero_q    <= 1'b0;
            i_wr_q       <= 1'b0;
            skip_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_vx_en_q   <= 1'b0;
            wb_vx_idx_q  <= 4'h0;
            wb_vx_data_q <= 8'h00;
            wb_vf_en_q   <= 1'b0;
            wb_vf_data_q <= 8'h00;
            wb_i_en_q    <= 1'b0;
            wb_i_data_q  <= 16'h0000;
            wb_skip_q    <= 1'b0;
            wb_illegal_q <= 1'b0;
            wb_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            req_q        <= req_d;
            x_idx_q      <= x_idx_d;
            vx_wr_q      <= vx_wr_d;
            vf_wr_q      <= vf_wr_d;
            vf_zero_q    <= vf_zero_d;
            i_wr_q       <= i_wr_d;
            skip_q       <= skip_d;
            wb_valid_q   <= wb_valid_d;
            wb_vx_en_q   <= wb_vx_en_d;
            wb_vx_idx_q  <= wb_vx_idx_d;
            wb_vx_data_q <= wb_vx_data_d;
            wb_vf_en_q   <= wb_vf_en_d;
            wb_vf_data_q <= wb_vf_data_d;
            wb_i_en_q    <= wb_i_en_d;
            wb_i_data_q  <= wb_i_data_d;
            wb_skip_q    <= wb_skip_d;
            wb_illegal_q <= wb_illegal_d;
            wb_timeout_q <= wb_timeout_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign alu_rst    = (state_q != ST_ISSUE);
    assign alu_req    = req_q;

    assign wb_valid   = wb_valid_q;
    assign wb_vx_en   = wb_vx_en_q;
    assign wb_vx_idx  = wb_vx_idx_q;
    assign wb_vx_data = wb_vx_data_q;
    assign wb_vf_en   = wb_vf_en_q;
    assign wb_vf_data = wb_vf_data_q;
    assign wb_i_en    = wb_i_en_q;
    assign wb_i_data  = wb_i_data_q;
    assign wb_skip    = wb_skip_q;
    assign wb_illegal = wb_illegal_q;
    assign wb_timeout = wb_timeout_q;

endmodule

// File: tb/tb_chip8_alu_dispatch.sv
// tb/tb_chip8_alu_dispatch.sv - self-checking bench for chip8_alu_dispatch
module tb_chip8_alu_dispatch;
    import chip8_alu_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_opcode;
    logic [7:0]  cmd_vx;
    logic [7:0]  cmd_vy;
    logic [15:0] cmd_i;
    logic        alu_rst;
    alu_input    alu_req;
    logic [7:0]  alu_result;
    logic [15:0] alu_result_long;
    logic        alu_overflow;
    logic        alu_done;
    logic        wb_valid, wb_vx_en, wb_vf_en, wb_i_en, wb_skip, wb_illegal, wb_timeout;
    logic [3:0]  wb_vx_idx;
    logic [7:0]  wb_vx_data, wb_vf_data;
    logic [15:0] wb_i_data;

    int n_checks = 0;
    int n_errors = 0;
    bit alu_stuck = 1'b0;
    int alu_cnt = 0;

    always #5 clk = ~clk;

    chip8_alu_dispatch #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_vx(cmd_vx), .cmd_vy(cmd_vy), .cmd_i(cmd_i),
        .alu_rst(alu_rst), .alu_req(alu_req),
        .alu_result(alu_result), .alu_result_long(alu_result_long),
        .alu_overflow(alu_overflow), .alu_done(alu_done),
        .wb_valid(wb_valid), .wb_vx_en(wb_vx_en), .wb_vx_idx(wb_vx_idx),
        .wb_vx_data(wb_vx_data), .wb_vf_en(wb_vf_en), .wb_vf_data(wb_vf_data),
        .wb_i_en(wb_i_en), .wb_i_data(wb_i_data), .wb_skip(wb_skip),
        .wb_illegal(wb_illegal), .wb_timeout(wb_timeout)
    );

    // Behavioural ALU: ADD/SUB take three cycles, everything else one.
    always @(posedge clk) begin
        if (alu_rst) begin
            alu_cnt  <= 0;
            alu_done <= 1'b0;
        end else if (!alu_stuck && !alu_done) begin
            if (alu_cnt + 1 >= ((alu_req.op == ALU_ADD || alu_req.op == ALU_SUB) ? 3 : 1)) begin
                alu_done <= 1'b1;
                alu_result_long <= 16'(alu_req.operand_a) + 16'(alu_req.operand_b_long);
                case (alu_req.op)
                    ALU_ADD: {alu_overflow, alu_result} <= 9'(alu_req.operand_a) + 9'(alu_req.operand_b);
                    ALU_SUB: begin
                        alu_result   <= alu_req.operand_a - alu_req.operand_b;
                        alu_overflow <= alu_req.operand_a >= alu_req.operand_b;
                    end
                    ALU_AND: begin alu_result <= alu_req.operand_a & alu_req.operand_b; alu_overflow <= 1'b1; end
                    ALU_OR:  begin alu_result <= alu_req.operand_a | alu_req.operand_b; alu_overflow <= 1'b1; end
                    ALU_XOR: begin alu_result <= alu_req.operand_a ^ alu_req.operand_b; alu_overflow <= 1'b1; end
                    ALU_SHR: begin alu_result <= alu_req.operand_a >> 1; alu_overflow <= alu_req.operand_a[0]; end
                    ALU_SHL: begin alu_result <= alu_req.operand_a << 1; alu_overflow <= alu_req.operand_a[7]; end
                    ALU_SE:  begin alu_result <= {7'b0, alu_req.operand_a == alu_req.operand_b}; alu_overflow <= 1'b0; end
                    ALU_SNE: begin alu_result <= {7'b0, alu_req.operand_a != alu_req.operand_b}; alu_overflow <= 1'b0; end
                    default: begin alu_result <= 8'hA5; alu_overflow <= 1'b1; end
                endcase
            end
            alu_cnt <= alu_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          lat;
        bit          vx_en;
        logic [7:0]  vx_data;
        bit          vf_en;
        logic [7:0]  vf_data;
        bit          i_en;
        logic [15:0] i_data;
        bit          skip;
        bit          illegal;
        bit          timeout;
        bit          uses_alu;
    } exp_t;

    // Instruction-level reference: what the CHIP-8 instruction should write.
    function automatic exp_t ref_model(input logic [15:0] op, input logic [7:0] vx,
                                       input logic [7:0] vy, input logic [15:0] iv);
        exp_t e;
        int   s;
        logic [7:0] nn = op[7:0];
        e = '{lat: 3, uses_alu: 1'b1, default: 0};
        case (op[15:12])
            4'h3: e.skip = (vx == nn);
            4'h4: e.skip = (vx != nn);
            4'h5: if (op[3:0] == 0) e.skip = (vx == vy); else e.illegal = 1;
            4'h9: if (op[3:0] == 0) e.skip = (vx != vy); else e.illegal = 1;
            4'h7: begin e.lat = 5; e.vx_en = 1; e.vx_data = 8'((int'(vx) + int'(nn)) % 256); end
            4'h8: begin
                e.vx_en = 1;
                case (op[3:0])
                    4'h0: begin e.lat = 1; e.uses_alu = 0; e.vx_data = vy; end
                    4'h1, 4'h2, 4'h3: begin
                        e.vx_data = (op[3:0] == 1) ? (vx | vy) : (op[3:0] == 2) ? (vx & vy) : (vx ^ vy);
`ifdef CHIP8_VF_RESET_QUIRK_EN
                        e.vf_en = 1; e.vf_data = 8'h00;
`endif
                    end
                    4'h4: begin
                        s = int'(vx) + int'(vy);
                        e.lat = 5; e.vx_data = 8'(s % 256); e.vf_en = 1; e.vf_data = (s > 255) ? 8'h01 : 8'h00;
                    end
                    4'h5: begin
                        e.lat = 5; e.vx_data = 8'((int'(vx) - int'(vy) + 256) % 256);
                        e.vf_en = 1; e.vf_data = (vx >= vy) ? 8'h01 : 8'h00;
                    end
                    4'h7: begin
                        e.lat = 5; e.vx_data = 8'((int'(vy) - int'(vx) + 256) % 256);
                        e.vf_en = 1; e.vf_data = (vy >= vx) ? 8'h01 : 8'h00;
                    end
                    4'h6: begin e.vx_data = 8'(int'(vx) / 2); e.vf_en = 1; e.vf_data = 8'(int'(vx) % 2); end
                    4'hE: begin e.vx_data = 8'((int'(vx) * 2) % 256); e.vf_en = 1; e.vf_data = (vx >= 8'h80) ? 8'h01 : 8'h00; end
                    default: begin e.vx_en = 0; e.illegal = 1; end
                endcase
            end
            4'hF: begin
                if (nn == 8'h1E) begin e.i_en = 1; e.i_data = 16'(int'(vx) + int'(iv % 4096)); end
                else e.illegal = 1;
            end
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin e.lat = 1; e.uses_alu = 0; end
        if (e.vf_en && op[11:8] == 4'hF) e.vx_en = 0;
        return e;
    endfunction

    task automatic run_cmd(input string tag, input logic [15:0] op, input logic [7:0] vx,
                           input logic [7:0] vy, input logic [15:0] iv, input bit stuck);
        exp_t e;
        int   n;
        bit   seen;
        e = ref_model(op, vx, vy, iv);
        if (stuck && e.uses_alu) e = '{lat: TMO + 1, timeout: 1'b1, uses_alu: 1'b1, default: 0};
        @(negedge clk);
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_vx = vx; cmd_vy = vy; cmd_i = iv;
        alu_stuck = stuck;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (wb_valid) seen = 1;
        end
        check({tag, ".lat"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(e.lat));
        if (seen) begin
            check({tag, ".illegal"}, 32'(wb_illegal), 32'(e.illegal));
            check({tag, ".timeout"}, 32'(wb_timeout), 32'(e.timeout));
            check({tag, ".vx_en"}, 32'(wb_vx_en), 32'(e.vx_en));
            if (e.vx_en) begin
                check({tag, ".vx_idx"}, 32'(wb_vx_idx), 32'(op[11:8]));
                check({tag, ".vx_data"}, 32'(wb_vx_data), 32'(e.vx_data));
            end
            check({tag, ".vf_en"}, 32'(wb_vf_en), 32'(e.vf_en));
            if (e.vf_en) check({tag, ".vf_data"}, 32'(wb_vf_data), 32'(e.vf_data));
            check({tag, ".i_en"}, 32'(wb_i_en), 32'(e.i_en));
            if (e.i_en) check({tag, ".i_data"}, 32'(wb_i_data), 32'(e.i_data));
            check({tag, ".skip"}, 32'(wb_skip), 32'(e.skip));
        end
        @(negedge clk);
        check({tag, ".post_wb"}, {26'b0, wb_valid, wb_vx_en, wb_vf_en, wb_i_en, wb_skip, wb_illegal | wb_timeout}, 32'd0);
        alu_stuck = 1'b0;
    endtask

    function automatic logic [15:0] rand_opcode();
        logic [3:0] x = 4'($urandom_range(0, 15));
        logic [3:0] y = 4'($urandom_range(0, 15));
        logic [7:0] k = 8'($urandom_range(0, 255));
        logic [3:0] lo;
        case ($urandom_range(0, 9))
            0: return {4'h7, x, k};
            1, 2, 3: begin
                lo = 4'($urandom_range(0, 15));
                return {4'h8, x, y, lo};
            end
            4: return {4'h3, x, k};
            5: return {4'h4, x, k};
            6: return {4'h5, x, y, 4'h0};
            7: return {4'h9, x, y, ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0};
            8: return {4'hF, x, ($urandom_range(0, 3) == 0) ? k : 8'h1E};
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        logic [15:0] op;
        logic [7:0]  a, b;
        rst_in = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_vx = '0; cmd_vy = '0; cmd_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(cmd_ready), 32'd1);
        check("rst.alu_rst", 32'(alu_rst), 32'd1);
        check("rst.alu_req", 32'(alu_req), 32'd0);
        check("rst.wb", {26'b0, wb_valid, wb_vx_en, wb_vf_en, wb_i_en, wb_skip, wb_illegal | wb_timeout}, 32'd0);
        rst_in = 1'b0;

        run_cmd("add_carry", 16'h8124, 8'hF0, 8'h20, 16'h0000, 0);
        run_cmd("sub_borrow", 16'h8125, 8'h10, 8'h20, 16'h0000, 0);
        run_cmd("sub_noborrow", 16'h8125, 8'h30, 8'h10, 16'h0000, 0);
        run_cmd("shl_vf", 16'h8F1E, 8'h81, 8'h81, 16'h0000, 0);
        run_cmd("addl", 16'hF31E, 8'h05, 8'h00, 16'h0FFE, 0);
        run_cmd("se_hit", 16'h3A42, 8'h42, 8'h00, 16'h0000, 0);
        run_cmd("sne_miss", 16'h4A42, 8'h42, 8'h00, 16'h0000, 0);
        run_cmd("mov", 16'h8340, 8'h11, 8'h77, 16'h0000, 0);
        run_cmd("illegal", 16'h812F, 8'h11, 8'h22, 16'h0000, 0);
        run_cmd("and", 16'h8012, 8'h0F, 8'h3C, 16'h0000, 0);
        run_cmd("or_vf", 16'h8F21, 8'h0F, 8'h30, 16'h0000, 0);
        run_cmd("timeout_add", 16'h8124, 8'h01, 8'h02, 16'h0000, 1);
        run_cmd("timeout_addl", 16'hF21E, 8'h01, 8'h00, 16'h0123, 1);

        // Reset in the middle of an ISSUE phase drops the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 16'h8124; cmd_vx = 8'h01; cmd_vy = 8'h02;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst.issue", 32'(alu_rst), 32'd0);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("midrst.ready", 32'(cmd_ready), 32'd1);
        check("midrst.alu_rst", 32'(alu_rst), 32'd1);
        check("midrst.alu_req", 32'(alu_req), 32'd0);
        begin
            bit any_wb = 0;
            repeat (8) begin
                @(negedge clk);
                if (wb_valid) any_wb = 1;
            end
            check("midrst.no_wb", 32'(any_wb), 32'd0);
        end

        for (int t = 0; t < 200; t++) begin
            op = rand_opcode();
            a  = 8'($urandom_range(0, 255));
            b  = (op[11:8] == op[7:4]) ? a : 8'($urandom_range(0, 255));
            if (op[15:12] == 4'h5 || op[15:12] == 4'h9)
                if ($urandom_range(0, 2) == 0) b = a;
            run_cmd("rand", op, a, b, 16'($urandom_range(0, 65535)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/chip8_alu_dispatch.md
Name: chip8_alu_dispatch

Overview:
Initiator side of the ALU request/done interface in the CHIP-8 core. It accepts one decoded arithmetic, logic, skip or I-add instruction with its operand values, and sequences the ALU through reset, issue and done-wait. It then produces a single-cycle writeback bundle for VX, VF, I and the skip flag. It sits between the instruction decoder/register file and the alu instance.

Parameters:
TIMEOUT_CYCLES, 15, max ISSUE cycles waiting for alu_done before aborting (min 4)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
cmd_valid  in  1  instruction offered
cmd_ready  out  1  dispatcher idle; accept when cmd_valid&&cmd_ready
cmd_opcode  in  16  raw CHIP-8 opcode
cmd_vx  in  8  value of V[opcode[11:8]]
cmd_vy  in  8  value of V[opcode[7:4]]
cmd_i  in  16  value of I
alu_rst  out  1  drives ALU rst_in
alu_req  out  alu_input (structs)  op, operand_a, operand_b, operand_b_long[11:0]
alu_result  in  8  ALU result
alu_result_long  in  16  ALU result_long
alu_overflow  in  1  ALU overflow
alu_done  in  1  ALU done (sticky until alu_rst)
wb_valid  out  1  one-cycle writeback strobe
wb_vx_en  out  1  write wb_vx_data to V[wb_vx_idx]
wb_vx_idx  out  4  X field
wb_vx_data  out  8  new VX
wb_vf_en  out  1  write wb_vf_data to VF
wb_vf_data  out  8  new VF (0x00/0x01)
wb_i_en  out  1  write wb_i_data to I
wb_i_data  out  16  new I
wb_skip  out  1  skip next instruction (valid with wb_valid)
wb_illegal  out  1  opcode not handled; no writes
wb_timeout  out  1  ALU never asserted done; no writes

Behaviour:
- States: IDLE, ISSUE, WB. cmd_ready=1 only in IDLE. alu_rst=1 in every state except ISSUE.
- Reset, including mid-operation: state IDLE; all wb_* outputs 0; alu_req zeroed; alu_rst=1; timeout counter 0. Any in-flight command is dropped silently.
- Accept at cycle T: latch opcode/operands, build alu_req, go to ISSUE at T+1. alu_req is held stable throughout ISSUE.
- Decode (a=operand_a, b=operand_b):
  - 7XNN: ADD, a=VX, b=NN; VX=result; VF untouched.
  - 8XY1/2/3: OR/AND/XOR, a=VX, b=VY; VX=result.
  - 8XY4: ADD, a=VX, b=VY; VX=result; VF=overflow.
  - 8XY5: SUB, a=VX, b=VY; VX=result; VF=overflow.
  - 8XY7: SUB, a=VY, b=VX; VX=result; VF=overflow.
  - 8XY6: SHR, a=VX, b=1; VX=result; VF=overflow.
  - 8XYE: SHL, a=VX, b=1; VX=result; VF=overflow.
  - 3XNN/5XY0: SE. 4XNN/9XY0: SNE. For these, b=NN or VY (5XY0/9XY0 need low nibble 0); wb_skip=result[0]; no register writes.
  - FX1E: ADDL, a=VX, operand_b_long=I[11:0]; I=result_long.
  - 8XY0: ALU bypassed, IDLE->WB directly; VX=VY; wb_valid at T+1.
  - Anything else: IDLE->WB with wb_illegal=1 at T+1.
- ISSUE: on the cycle alu_done is sampled 1, capture alu_result/alu_result_long/alu_overflow and go to WB.
  - Latency: single-step ops (logic/shift/SE/SNE/ADDL) give wb_valid at T+3.
  - ADD/SUB (3-cycle ALU) give wb_valid at T+5.
  - If TIMEOUT_CYCLES ISSUE cycles elapse without done, go to WB with wb_timeout=1 and all enables 0.
- WB: wb_valid=1 for exactly one cycle, then IDLE. All wb_* fields are 0 outside WB.
- VF results are 0x00/0x01 (zero-extended flag).
- When X==F and wb_vf_en=1, the flag wins: wb_vx_en=0, and wb_vf_data carries the flag.
- A new command is never accepted in the WB cycle. Back-to-back throughput is WB->IDLE->accept.

Optional Feature:
CHIP8_VF_RESET_QUIRK_EN. Defined: 8XY1/8XY2/8XY3 additionally assert wb_vf_en with wb_vf_data=0x00 (COSMAC VIP behaviour); X==F follows the flag-wins rule. Undefined: logic ops leave VF untouched.

Test Plan:
- 8124, V1=0xF0, V2=0x20 -> wb_valid at T+5; VX idx1=0x10; VF=0x01.
- 8125, V1=0x10, V2=0x20 -> VX=0xF0, VF=0x00. Then 8125 with V1=0x30, V2=0x10 -> VX=0x20, VF=0x01.
- 8F1E, VF=0x81 -> wb_vx_en=0, wb_vf_en=1, wb_vf_data=0x01, at T+3.
- F31E, V3=0x05, I=0x0FFE -> wb_i_en=1, wb_i_data=0x1003. 3A42 with VA=0x42 -> wb_skip=1, no enables.
- alu_done tied 0 -> wb_timeout after TIMEOUT_CYCLES. Opcode 8XYF -> wb_illegal at T+1. rst_in pulsed during ISSUE -> IDLE next cycle, no wb_valid, cmd_ready=1.
- With CHIP8_VF_RESET_QUIRK_EN: 8012, V0=0x0F, V1=0x3C -> VX=0x0C, VF=0x00. Without it: wb_vf_en=0.
